// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
// Module : core_pkg
// Brief  : Shared types and constants for the RV32I single-cycle core.
// Rev    : 1.0 - initial release
// ============================================================================
package core_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        WB_ALU = 2'b00,
        WB_MEM = 2'b01,
        WB_PC4 = 2'b10,
        WB_RSV = 2'b11
    } wb_sel_e;

endpackage : core_pkg
`default_nettype wire

// File: rtl/mux_wb.sv
`default_nettype none
// ============================================================================
// Module : mux_wb
// Brief  : Write-back source selector (ALU / memory / PC+4), optional output
//          register and sticky illegal-select flag.
// Rev    : 1.0 - initial release
// ============================================================================
module mux_wb
    import core_pkg::*;
#(
    parameter int XLEN    = core_pkg::XLEN,
    parameter bit REG_OUT = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] alu_result,
    input  logic [XLEN-1:0] mem_data,
    input  logic [XLEN-1:0] pc_plus4,
    input  logic [1:0]      MemToReg,
    output logic [XLEN-1:0] wb_data,
    output logic            sel_err
);

    wb_sel_e         w_sel;
    logic [XLEN-1:0] w_sel_data;
    logic            r_sel_err;

    assign w_sel = wb_sel_e'(MemToReg);

    // Reserved and unknown encodings resolve to zero so wb_data is never X.
    always_comb begin
        w_sel_data = '0;
        unique case (w_sel)
            WB_ALU:  w_sel_data = alu_result;
            WB_MEM:  w_sel_data = mem_data;
            WB_PC4:  w_sel_data = pc_plus4;
            WB_RSV:  w_sel_data = '0;
            default: w_sel_data = '0;
        endcase
    end

    generate
        if (REG_OUT) begin : g_reg_out
            logic [XLEN-1:0] r_wb_data;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_wb_data <= '0;
                end else begin
                    r_wb_data <= w_sel_data;
                end
            end

            assign wb_data = r_wb_data;
        end else begin : g_comb_out
            assign wb_data = w_sel_data;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sel_err <= 1'b0;
        end else if (w_sel == WB_RSV) begin
            r_sel_err <= 1'b1;
        end
    end

    assign sel_err = r_sel_err;

endmodule : mux_wb
`default_nettype wire

// File: tb/tb_mux_wb.sv
`default_nettype none
// ============================================================================
// Module : tb_mux_wb
// Brief  : Scoreboard bench for mux_wb, combinational and registered variants.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_mux_wb;

    localparam int XLEN = 32;

    // Observation points on the two DUT instances.
    localparam int P_COMB_WB  = 0;
    localparam int P_REG_WB   = 1;
    localparam int P_COMB_ERR = 2;
    localparam int P_REG_ERR  = 3;

    typedef struct {
        string       name;
        int          point;
        logic [31:0] exp;
    } exp_t;

    logic            clk;
    logic            rst;
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] mem_data;
    logic [XLEN-1:0] pc_plus4;
    logic [1:0]      MemToReg;
    logic [XLEN-1:0] wb_comb;
    logic [XLEN-1:0] wb_reg;
    logic            err_comb;
    logic            err_reg;

    exp_t q[$];
    event chk_ev;
    int   tests_run;
    int   tests_failed;

    mux_wb #(.XLEN(XLEN), .REG_OUT(1'b0)) u_dut_comb (
        .clk        (clk),
        .rst        (rst),
        .alu_result (alu_result),
        .mem_data   (mem_data),
        .pc_plus4   (pc_plus4),
        .MemToReg   (MemToReg),
        .wb_data    (wb_comb),
        .sel_err    (err_comb)
    );

    mux_wb #(.XLEN(XLEN), .REG_OUT(1'b1)) u_dut_reg (
        .clk        (clk),
        .rst        (rst),
        .alu_result (alu_result),
        .mem_data   (mem_data),
        .pc_plus4   (pc_plus4),
        .MemToReg   (MemToReg),
        .wb_data    (wb_reg),
        .sel_err    (err_reg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] observe(input int point);
        case (point)
            P_COMB_WB:  return wb_comb;
            P_REG_WB:   return wb_reg;
            P_COMB_ERR: return {31'd0, err_comb};
            default:    return {31'd0, err_reg};
        endcase
    endfunction

    // Monitor: drains the scoreboard each time a sample point is announced.
    initial begin
        tests_run    = 0;
        tests_failed = 0;
        forever begin
            @(chk_ev);
            while (q.size() > 0) begin
                exp_t        e;
                logic [31:0] act;
                e   = q.pop_front();
                act = observe(e.point);
                tests_run++;
                if (act !== e.exp) begin
                    tests_failed++;
                    $display("FAIL %s: got 0x%08h expected 0x%08h at %0t",
                             e.name, act, e.exp, $time);
                end
            end
        end
    end

    task automatic expect_val(input string name, input int point, input logic [31:0] exp);
        exp_t e;
        e.name  = name;
        e.point = point;
        e.exp   = exp;
        q.push_back(e);
    endtask

    task automatic sample();
        #1;
        ->chk_ev;
        #1;
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst        = 1'b1;
        alu_result = 32'd100;
        mem_data   = 32'd555;
        pc_plus4   = 32'd204;
        MemToReg   = 2'b00;

        // Reset state; combinational path ignores rst.
        #3;
        expect_val("rst_reg_wb",   P_REG_WB,   32'd0);
        expect_val("rst_reg_err",  P_REG_ERR,  32'd0);
        expect_val("rst_comb_err", P_COMB_ERR, 32'd0);
        expect_val("rst_comb_alu", P_COMB_WB,  32'd100);
        sample();

        // Held in reset across an edge.
        after_edge();
        expect_val("rst_hold_reg_wb", P_REG_WB, 32'd0);
        sample();

        @(negedge clk);
        rst      = 1'b0;
        MemToReg = 2'b01;
        expect_val("comb_mem",        P_COMB_WB, 32'd555);
        expect_val("reg_mem_pre_edge", P_REG_WB, 32'd0);
        sample();
        after_edge();
        expect_val("reg_mem_post_edge", P_REG_WB, 32'd555);
        sample();

        @(negedge clk);
        MemToReg = 2'b10;
        expect_val("comb_pc4",      P_COMB_WB, 32'd204);
        expect_val("reg_pc4_hold",  P_REG_WB,  32'd555);
        sample();
        after_edge();
        expect_val("reg_pc4",       P_REG_WB,  32'd204);
        sample();

        @(negedge clk);
        alu_result = 32'hFFFF_FFFF;
        MemToReg   = 2'b00;
        expect_val("comb_alu_ones", P_COMB_WB, 32'hFFFF_FFFF);
        sample();
        after_edge();
        expect_val("reg_alu_ones",  P_REG_WB,  32'hFFFF_FFFF);
        sample();

        @(negedge clk);
        pc_plus4 = 32'h0000_0000;
        mem_data = 32'h8000_0001;
        MemToReg = 2'b10;
        expect_val("comb_pc4_zero", P_COMB_WB, 32'h0000_0000);
        sample();
        MemToReg = 2'b01;
        expect_val("comb_mem_msb",  P_COMB_WB, 32'h8000_0001);
        sample();

        // Illegal select: zero output, flag set only on the edge.
        @(negedge clk);
        MemToReg = 2'b11;
        expect_val("comb_rsv_zero",      P_COMB_WB,  32'd0);
        expect_val("comb_err_pre_edge",  P_COMB_ERR, 32'd0);
        expect_val("reg_err_pre_edge",   P_REG_ERR,  32'd0);
        sample();
        after_edge();
        expect_val("comb_err_set",       P_COMB_ERR, 32'd1);
        expect_val("reg_err_set",        P_REG_ERR,  32'd1);
        expect_val("reg_rsv_zero",       P_REG_WB,   32'd0);
        sample();

        @(negedge clk);
        MemToReg = 2'b00;
        expect_val("comb_alu_after_rsv", P_COMB_WB,  32'hFFFF_FFFF);
        sample();
        after_edge();
        after_edge();
        expect_val("comb_err_sticky",    P_COMB_ERR, 32'd1);
        expect_val("reg_err_sticky",     P_REG_ERR,  32'd1);
        expect_val("reg_alu_after_rsv",  P_REG_WB,   32'hFFFF_FFFF);
        sample();

        // Asynchronous reset between edges.
        @(negedge clk);
        #1;
        rst = 1'b1;
        expect_val("async_reg_wb",   P_REG_WB,   32'd0);
        expect_val("async_reg_err",  P_REG_ERR,  32'd0);
        expect_val("async_comb_err", P_COMB_ERR, 32'd0);
        expect_val("async_comb_wb",  P_COMB_WB,  32'hFFFF_FFFF);
        sample();

        @(negedge clk);
        rst      = 1'b0;
        mem_data = 32'h1234_5678;
        MemToReg = 2'b01;
        after_edge();
        expect_val("reg_first_edge_load", P_REG_WB, 32'h1234_5678);
        expect_val("err_stays_clear",     P_REG_ERR, 32'd0);
        sample();

        for (int i = 0; i < 100 && q.size() > 0; i++) #1;
        if (q.size() != 0) begin
            tests_failed++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_mux_wb
`default_nettype wire
